// File: rtl/detector_jogada.sv
//------------------------------------------------------------------------------
// detector_jogada
//
// Input-conditioning stage for the memory-game datapath. The four raw player
// keys are synchronised, debounced as a whole vector, and then screened by a
// small Moore FSM. A play is accepted only when exactly one key is pressed.
// An accepted play is presented as a registered one-hot code with a one-cycle
// strobe. A multi-key press produces a one-cycle rejection strobe instead.
// After either outcome, all keys must be released before the next play can
// be taken. Keys held across plays are therefore never accepted twice.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive cycles the synchronised vector must differ
//                     from the filtered vector before the change is accepted
//                     (>= 1)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clock               in   system clock, rising edge
//   reset               in   synchronous, active-low reset
//   habilita            in   1 = plays may be captured (from control unit)
//   chaves[3:0]         in   raw asynchronous key levels, 1 = pressed
//   jogada[3:0]         out  registered one-hot code of last accepted play
//   jogada_feita        out  one-cycle strobe, jogada valid in same cycle
//   chave_invalida      out  one-cycle strobe, multi-key press rejected
//   db_chaves_filtradas out  debounced key vector
//   db_estado[3:0]      out  FSM state code (0..4) for the 7-segment display
//------------------------------------------------------------------------------
module detector_jogada #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [3:0] chaves,
   output logic [3:0] jogada,
   output logic       jogada_feita,
   output logic       chave_invalida,
   output logic [3:0] db_chaves_filtradas,
   output logic [3:0] db_estado
);

   typedef enum logic [2:0] {
      DESABILITADO  = 3'd0,
      AGUARDA_LIVRE = 3'd1,
      AGUARDA_TECLA = 3'd2,
      REGISTRA      = 3'd3,
      INVALIDA      = 3'd4
   } estado_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       sync_a;
   logic [3:0]       sync_b;
   logic [3:0]       filtradas;
   logic [CNT_W-1:0] contador;

   estado_t          estado;
   estado_t          proximo;
   logic             carrega_jogada;
   logic             uma_tecla;
   logic             alguma_tecla;

   //---------------------------------------------------------------------------
   // Two-flop synchroniser and whole-vector debounce.
   // The counter measures how long the synchronised vector has differed from
   // the filtered one, not how long it has held one particular value. A
   // vector that keeps changing, while never matching the filtered value, is
   // still accepted after DEBOUNCE_CYCLES cycles. The value accepted is
   // whatever is present at that moment.
   //---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_a    <= 4'b0000;
         sync_b    <= 4'b0000;
         filtradas <= 4'b0000;
         contador  <= '0;
      end else begin
         sync_a <= chaves;
         sync_b <= sync_a;
         if (sync_b == filtradas) begin
            contador <= '0;
         end else if (contador == CNT_LAST) begin
            filtradas <= sync_b;
            contador  <= '0;
         end else begin
            contador <= contador + CNT_W'(1);
         end
      end
   end

   // Exactly one bit set: non-zero, and clearing the lowest set bit leaves 0.
   assign alguma_tecla = (filtradas != 4'b0000);
   assign uma_tecla    = alguma_tecla && ((filtradas & (filtradas - 4'd1)) == 4'b0000);

   //---------------------------------------------------------------------------
   // FSM state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado <= DESABILITADO;
      end else begin
         estado <= proximo;
      end
   end

   //---------------------------------------------------------------------------
   // Next state and Moore outputs. Dropping habilita wins over every other
   // transition. A strobe state that is already active still shows its output
   // for the current cycle, because the outputs depend only on the state.
   //---------------------------------------------------------------------------
   always_comb begin
      proximo        = estado;
      carrega_jogada = 1'b0;
      jogada_feita   = 1'b0;
      chave_invalida = 1'b0;

      case (estado)
         DESABILITADO: begin
            if (habilita) begin
               proximo = AGUARDA_LIVRE;
            end
         end
         AGUARDA_LIVRE: begin
            if (!alguma_tecla) begin
               proximo = AGUARDA_TECLA;
            end
         end
         AGUARDA_TECLA: begin
            if (uma_tecla) begin
               proximo        = REGISTRA;
               carrega_jogada = 1'b1;
            end else if (alguma_tecla) begin
               proximo = INVALIDA;
            end
         end
         REGISTRA: begin
            jogada_feita = 1'b1;
            proximo      = AGUARDA_LIVRE;
         end
         INVALIDA: begin
            chave_invalida = 1'b1;
            proximo        = AGUARDA_LIVRE;
         end
         default: begin
            proximo = DESABILITADO;
         end
      endcase

      if (!habilita) begin
         proximo        = DESABILITADO;
         carrega_jogada = 1'b0;
      end
   end

   //---------------------------------------------------------------------------
   // Play register: loaded on the same edge that enters REGISTRA, so the code
   // is already valid while jogada_feita is high. Dropping habilita does not
   // clear it.
   //---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         jogada <= 4'b0000;
      end else if (carrega_jogada) begin
         jogada <= filtradas;
      end
   end

   assign db_chaves_filtradas = filtradas;
   assign db_estado           = {1'b0, estado};

endmodule

// File: tb/tb_detector_jogada.sv
module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic [3:0] chaves;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       chave_invalida;
  logic [3:0] db_chaves_filtradas;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  detector_jogada #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .habilita(habilita),
    .chaves(chaves),
    .jogada(jogada),
    .jogada_feita(jogada_feita),
    .chave_invalida(chave_invalida),
    .db_chaves_filtradas(db_chaves_filtradas),
    .db_estado(db_estado)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // advance n edges and record strobe counts and the first edge index of each
  task automatic watch(input int n, output int nf, output int ni,
                       output int ff, output int fi);
    nf = 0; ni = 0; ff = 0; fi = 0;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (jogada_feita === 1'b1) begin
        nf++;
        if (ff == 0) ff = i;
      end
      if (chave_invalida === 1'b1) begin
        ni++;
        if (fi == 0) fi = i;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; habilita = 1'b0; chaves = 4'b0000;
    step(2);
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado got=%0d exp=0", db_estado); end
    checks++; if (jogada !== 4'b0000) begin errors++; $display("FAIL reset_jogada got=%b exp=0000", jogada); end
    checks++; if (jogada_feita !== 1'b0 || chave_invalida !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", jogada_feita, chave_invalida); end
    checks++; if (db_chaves_filtradas !== 4'b0000) begin errors++; $display("FAIL reset_filtradas got=%b exp=0000", db_chaves_filtradas); end
    reset = 1'b1; habilita = 1'b1;
    step(1);
    checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL enable_estado1 got=%0d exp=1", db_estado); end
    step(1);
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL enable_estado2 got=%0d exp=2", db_estado); end
  endtask

  task automatic test_single_press();
    int nf, ni, ff, fi;
    chaves = 4'b0100;
    watch(20, nf, ni, ff, fi);
    checks++; if (nf !== 1) begin errors++; $display("FAIL single_count got=%0d exp=1", nf); end
    checks++; if (ff !== 7) begin errors++; $display("FAIL single_latency got=%0d exp=7", ff); end
    checks++; if (ni !== 0) begin errors++; $display("FAIL single_invalid got=%0d exp=0", ni); end
    checks++; if (jogada !== 4'b0100) begin errors++; $display("FAIL single_jogada got=%b exp=0100", jogada); end
    checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL single_held_estado got=%0d exp=1", db_estado); end
    checks++; if (db_chaves_filtradas !== 4'b0100) begin errors++; $display("FAIL single_filtradas got=%b exp=0100", db_chaves_filtradas); end
    chaves = 4'b0000;
    step(7);
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL single_release_estado got=%0d exp=2", db_estado); end
    checks++; if (db_chaves_filtradas !== 4'b0000) begin errors++; $display("FAIL single_release_filtradas got=%b exp=0000", db_chaves_filtradas); end
  endtask

  task automatic test_glitch();
    int nf = 0;
    int ni = 0;
    int leaked = 0;
    chaves = 4'b0001;
    for (int i = 1; i <= 14; i++) begin
      if (i == 4) chaves = 4'b0000;
      step(1);
      if (jogada_feita === 1'b1) nf++;
      if (chave_invalida === 1'b1) ni++;
      if (db_chaves_filtradas !== 4'b0000) leaked++;
    end
    checks++; if (leaked !== 0) begin errors++; $display("FAIL glitch_filtradas got=%0d nonzero cycles exp=0", leaked); end
    checks++; if (nf !== 0 || ni !== 0) begin errors++; $display("FAIL glitch_strobes got=%0d/%0d exp=0/0", nf, ni); end
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL glitch_estado got=%0d exp=2", db_estado); end
  endtask

  task automatic test_invalid();
    int nf, ni, ff, fi;
    chaves = 4'b0011;
    watch(20, nf, ni, ff, fi);
    checks++; if (ni !== 1) begin errors++; $display("FAIL invalid_count got=%0d exp=1", ni); end
    checks++; if (fi !== 7) begin errors++; $display("FAIL invalid_latency got=%0d exp=7", fi); end
    checks++; if (nf !== 0) begin errors++; $display("FAIL invalid_feita got=%0d exp=0", nf); end
    checks++; if (jogada !== 4'b0100) begin errors++; $display("FAIL invalid_jogada got=%b exp=0100", jogada); end
    chaves = 4'b0000;
    step(10);
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL invalid_release_estado got=%0d exp=2", db_estado); end
  endtask

  task automatic test_held_enable();
    int nf, ni, ff, fi;
    habilita = 1'b0;
    step(1);
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL held_disable_estado got=%0d exp=0", db_estado); end
    chaves = 4'b1000;
    step(10);
    checks++; if (db_chaves_filtradas !== 4'b1000 || db_estado !== 4'd0) begin errors++; $display("FAIL held_disabled got=%b/%0d exp=1000/0", db_chaves_filtradas, db_estado); end
    habilita = 1'b1;
    watch(10, nf, ni, ff, fi);
    checks++; if (nf !== 0 || ni !== 0) begin errors++; $display("FAIL held_enable_strobes got=%0d/%0d exp=0/0", nf, ni); end
    checks++; if (db_estado !== 4'd1) begin errors++; $display("FAIL held_enable_estado got=%0d exp=1", db_estado); end
    chaves = 4'b0000;
    watch(10, nf, ni, ff, fi);
    checks++; if (nf !== 0 || ni !== 0) begin errors++; $display("FAIL held_release_strobes got=%0d/%0d exp=0/0", nf, ni); end
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL held_release_estado got=%0d exp=2", db_estado); end
    chaves = 4'b0010;
    watch(20, nf, ni, ff, fi);
    checks++; if (nf !== 1 || ff !== 7) begin errors++; $display("FAIL held_next_press got=%0d@%0d exp=1@7", nf, ff); end
    checks++; if (jogada !== 4'b0010) begin errors++; $display("FAIL held_next_jogada got=%b exp=0010", jogada); end
    chaves = 4'b0000;
    step(10);
  endtask

  // a press lasting exactly DEBOUNCE_CYCLES synchronised cycles is accepted
  task automatic test_min_pulse();
    int nf = 0;
    int ff = 0;
    chaves = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) chaves = 4'b0000;
      step(1);
      if (jogada_feita === 1'b1) begin
        nf++;
        if (ff == 0) ff = i;
      end
    end
    checks++; if (nf !== 1 || ff !== 7) begin errors++; $display("FAIL min_pulse got=%0d@%0d exp=1@7", nf, ff); end
    checks++; if (jogada !== 4'b0001) begin errors++; $display("FAIL min_pulse_jogada got=%b exp=0001", jogada); end
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL min_pulse_estado got=%0d exp=2", db_estado); end
  endtask

  task automatic test_habilita_drop();
    int nf, ni, ff, fi;
    chaves = 4'b0100;
    step(5);
    habilita = 1'b0;
    step(1);
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL drop_estado got=%0d exp=0", db_estado); end
    checks++; if (db_chaves_filtradas !== 4'b0100) begin errors++; $display("FAIL drop_filtradas got=%b exp=0100", db_chaves_filtradas); end
    watch(10, nf, ni, ff, fi);
    checks++; if (nf !== 0 || ni !== 0) begin errors++; $display("FAIL drop_strobes got=%0d/%0d exp=0/0", nf, ni); end
    checks++; if (jogada !== 4'b0001) begin errors++; $display("FAIL drop_jogada got=%b exp=0001", jogada); end
    chaves = 4'b0000; habilita = 1'b1;
    step(10);
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL drop_recover_estado got=%0d exp=2", db_estado); end
  endtask

  task automatic test_reset_in_registra();
    chaves = 4'b1000;
    step(7);
    checks++; if (jogada_feita !== 1'b1 || db_estado !== 4'd3) begin errors++; $display("FAIL rst_reg_setup got=%b/%0d exp=1/3", jogada_feita, db_estado); end
    reset = 1'b0;
    step(1);
    checks++; if (jogada !== 4'b0000) begin errors++; $display("FAIL rst_reg_jogada got=%b exp=0000", jogada); end
    checks++; if (jogada_feita !== 1'b0 || chave_invalida !== 1'b0) begin errors++; $display("FAIL rst_reg_strobes got=%b%b exp=00", jogada_feita, chave_invalida); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL rst_reg_estado got=%0d exp=0", db_estado); end
    checks++; if (db_chaves_filtradas !== 4'b0000) begin errors++; $display("FAIL rst_reg_filtradas got=%b exp=0000", db_chaves_filtradas); end
    reset = 1'b1; chaves = 4'b0000;
    step(2);
    checks++; if (db_estado !== 4'd2) begin errors++; $display("FAIL rst_reg_recover got=%0d exp=2", db_estado); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_invalid();
    test_held_enable();
    test_min_pulse();
    test_habilita_drop();
    test_reset_in_registra();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Input-conditioning stage directly upstream of the memory-game datapath.
- Takes the four raw player keys (chaves) and synchronises and debounces them.
- Accepts only single-key presses and emits a registered one-hot play code plus a one-cycle jogada_feita strobe.
- The downstream register/compare logic consumes this code instead of raw key levels; the control unit gates the block with habilita.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a key change is accepted (1 ms at 50 MHz); legal range >= 1
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
habilita  input  1  from control unit; 1 = plays may be captured
chaves  input  4  raw asynchronous key levels, 1 = pressed
jogada  output  4  registered one-hot code of last accepted play
jogada_feita  output  1  one-cycle strobe, jogada valid in same cycle
chave_invalida  output  1  one-cycle strobe, multi-key press rejected
db_chaves_filtradas  output  4  debounced key vector
db_estado  output  4  FSM state code, for hexa7seg display

Behaviour:
- Reset: one clock; reset is synchronous and active-low. While reset=0 at a rising edge, all of the following clear:
  - sync stages, filtered vector and debounce counter -> 0
  - jogada -> 0, jogada_feita -> 0, chave_invalida -> 0
  - state -> DESABILITADO
  - reset overrides every other input, including reset asserted mid-debounce or in REGISTRA (no strobe is emitted).
- Synchroniser: 2-flop chain per bit; sync = chaves delayed 2 edges.
- Debounce (whole 4-bit vector):
  - If sync == filtered, the counter clears to 0.
  - Otherwise the counter increments each cycle.
  - When the counter == DEBOUNCE_CYCLES-1 and sync != filtered: filtered <= sync and the counter clears.
  - Any change in sync before acceptance does not reset the count (counter measures difference, not identity). The vector must therefore stay different for DEBOUNCE_CYCLES consecutive cycles.
  - Glitches shorter than DEBOUNCE_CYCLES never reach filtered.
- FSM (Moore; transitions on rising edge; db_estado code in brackets):
  - DESABILITADO [0]: go to AGUARDA_LIVRE when habilita=1.
  - AGUARDA_LIVRE [1]: go to AGUARDA_TECLA when filtered==0. Keys held from a previous play are never re-accepted.
  - AGUARDA_TECLA [2]: when filtered!=0:
    - exactly one bit set -> REGISTRA; jogada <= filtered on the same edge.
    - two or more bits set -> INVALIDA.
  - REGISTRA [3]: jogada_feita=1 for exactly this cycle; then AGUARDA_LIVRE.
  - INVALIDA [4]: chave_invalida=1 for exactly this cycle; then AGUARDA_LIVRE.
  - habilita=0 in any state -> DESABILITADO on the next edge; this has priority over all other transitions.
  - A strobe already in REGISTRA/INVALIDA still completes its single cycle.
- jogada holds its value until the next accepted play or reset; it is not cleared by habilita=0.
- Latency: raw press stable from edge t -> filtered updates at edge t+2+DEBOUNCE_CYCLES -> jogada_feita high in the cycle after edge t+3+DEBOUNCE_CYCLES.
  - Example: DEBOUNCE_CYCLES=4 gives the strobe 7 edges after the press.
- Only one strobe per press; at most one of jogada_feita / chave_invalida is high in any cycle.
- Staggered press (second key arrives after the first is accepted): the first key is the play; the FSM waits in AGUARDA_LIVRE until all keys are released.
- Undefined state codes recover to DESABILITADO.

Test Plan:
1. DEBOUNCE_CYCLES=4, reset=0 for 2 edges, then habilita=1; chaves=0100 held 20 cycles -> db_estado 0->1->2; jogada_feita single pulse 7 edges after press; jogada=0100; no second pulse while held; release -> state 2.
2. 3-cycle glitch chaves=0001 then 0000 -> db_chaves_filtradas stays 0000; no strobe; state remains 2.
3. chaves=0011 held -> chave_invalida single pulse; jogada keeps previous 0100; jogada_feita never asserted.
4. Press 1000 with habilita=0, then raise habilita while still held -> no strobe until release; the next press of 0010 gives a jogada_feita pulse with jogada=0010.
5. reset=0 asserted in the REGISTRA cycle -> next cycle: jogada=0000, strobes 0, db_estado=0, filtered=0000.
6. habilita dropped during AGUARDA_TECLA while filtered is changing -> state 0 next edge; no strobe; jogada unchanged.
